// File: rtl/block_reader_160_if.sv
// block_reader_160_if: control, block input and word-stream handshake of the 160-bit block reader.
interface block_reader_160_if #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 5,
   parameter int IDX_W     = 3
);
   logic                          start;
   logic                          abort;
   logic [WORD_W*NUM_WORDS-1:0]   block_in;
   logic [WORD_W-1:0]             word_out;
   logic                          word_valid;
   logic                          word_ready;
   logic                          word_last;
   logic [IDX_W-1:0]              word_idx;
   logic                          busy;
   logic                          done;
   modport master (
      input  start, abort, block_in, word_ready,
      output word_out, word_valid, word_last, word_idx, busy, done
   );
   modport slave (
      output start, abort, block_in, word_ready,
      input  word_out, word_valid, word_last, word_idx, busy, done
   );
endinterface

// File: rtl/block_reader_160.sv
// block_reader_160: snapshots a stored block on start and streams it MS-word first as
// valid/ready words with index/last tags and a done pulse.
module block_reader_160 #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 5,
   parameter int IDX_W     = 3
) (
   input logic CLK,
   input logic RST,
   block_reader_160_if.master br
);
   localparam int BLK_W = WORD_W * NUM_WORDS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
   state_t            state_q;
   logic [BLK_W-1:0]  snap_q, snap_d;
   logic [WORD_W-1:0] word_q;
   logic [IDX_W-1:0]  idx_q;
   logic              valid_q, last_q, busy_q, done_q, xfer;
   assign xfer   = valid_q && br.word_ready;
   // The snapshot is kept pre-shifted so its top word is always the next word to present.
   assign snap_d = snap_q << WORD_W;
   assign br.word_out   = word_q;
   assign br.word_valid = valid_q;
   assign br.word_last  = last_q;
   assign br.word_idx   = idx_q;
   assign br.busy       = busy_q;
   assign br.done       = done_q;
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         snap_q  <= '0;
         word_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (br.start) begin
               snap_q  <= br.block_in << WORD_W;
               word_q  <= br.block_in[BLK_W-1 -: WORD_W];
               idx_q   <= '0;
               valid_q <= 1'b1;
               last_q  <= (NUM_WORDS == 1);
               busy_q  <= 1'b1;
               state_q <= SEND;
            end
            SEND: if (br.abort) begin
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               idx_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end else if (xfer) begin
               if (idx_q == LAST_IDX) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q  <= idx_q + 1'b1;
                  word_q <= snap_q[BLK_W-1 -: WORD_W];
                  snap_q <= snap_d;
                  last_q <= (idx_q + 1'b1 == LAST_IDX);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_block_reader_160.sv
// tb_block_reader_160: directed checks of the block reader's stream order, handshake stalls,
// snapshot, ignored start, abort and async reset.
module tb_block_reader_160;
   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   n_asrt = 0;
   int   n_fail = 0;
   logic [159:0] blk = 160'h00112233_44556677_8899AABB_CCDDEEFF_01234567;
   logic [31:0]  exp_w [5] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 32'h01234567};
   block_reader_160_if br ();
   block_reader_160 dut (.CLK(CLK), .RST(RST), .br(br));
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge CLK);
      #1;
   endtask
   task automatic start_pulse();
      br.start = 1'b1;
      step();
      br.start = 1'b0;
   endtask
   // Streams 5 words with ready=1; optionally pulses start while word 2 is presented.
   task automatic stream5(input string tag, input bit poke_start);
      for (int k = 0; k < 5; k++) begin
         chk({tag, "_word"}, br.word_out, exp_w[k]);
         chk({tag, "_idx"}, 32'(br.word_idx), 32'(k));
         chk({tag, "_valid"}, 32'(br.word_valid), 32'd1);
         chk({tag, "_last"}, 32'(br.word_last), 32'(k == 4));
         chk({tag, "_nodone"}, 32'(br.done), 32'd0);
         br.start = poke_start && (k == 2);
         step();
         br.start = 1'b0;
      end
      chk({tag, "_done"}, 32'(br.done), 32'd1);
      chk({tag, "_valid_off"}, 32'(br.word_valid), 32'd0);
      chk({tag, "_busy_done"}, 32'(br.busy), 32'd1);
      br.start = poke_start;
      step();
      br.start = 1'b0;
      chk({tag, "_done_once"}, 32'(br.done), 32'd0);
      chk({tag, "_idle_busy"}, 32'(br.busy), 32'd0);
      step();
      chk({tag, "_no_restart"}, 32'(br.word_valid), 32'd0);
   endtask
   initial begin
      br.start = 1'b0;
      br.abort = 1'b0;
      br.block_in = blk;
      br.word_ready = 1'b0;
      #12 RST = 1'b1;
      step();
      // 1: idle after reset
      for (int i = 0; i < 3; i++) step();
      chk("rst_valid", 32'(br.word_valid), 32'd0);
      chk("rst_busy", 32'(br.busy), 32'd0);
      chk("rst_done", 32'(br.done), 32'd0);
      chk("rst_word", br.word_out, 32'd0);
      chk("rst_idx", 32'(br.word_idx), 32'd0);
      // 2: back-to-back stream
      br.word_ready = 1'b1;
      start_pulse();
      stream5("basic", 1'b0);
      // 3: ready toggling 1,0,0,...
      start_pulse();
      begin
         int k = 0;
         int c = 0;
         while (k < 5 && c < 40) begin
            br.word_ready = (c % 3 == 0);
            chk("stall_word", br.word_out, exp_w[k]);
            chk("stall_idx", 32'(br.word_idx), 32'(k));
            chk("stall_valid", 32'(br.word_valid), 32'd1);
            chk("stall_nodone", 32'(br.done), 32'd0);
            step();
            if (br.word_ready) k++;
            c++;
         end
         chk("stall_count", 32'(k), 32'd5);
      end
      br.word_ready = 1'b1;
      chk("stall_done", 32'(br.done), 32'd1);
      step();
      chk("stall_done_once", 32'(br.done), 32'd0);
      step();
      // 4: snapshot isolates the stream from block_in changes
      start_pulse();
      br.block_in = '1;
      stream5("snap", 1'b0);
      br.block_in = blk;
      // 5: start during SEND and DONE ignored
      start_pulse();
      stream5("ignore", 1'b1);
      // 6: abort at idx 2, then a fresh stream
      start_pulse();
      step();
      step();
      chk("abort_pre_idx", 32'(br.word_idx), 32'd2);
      br.abort = 1'b1;
      step();
      br.abort = 1'b0;
      chk("abort_valid", 32'(br.word_valid), 32'd0);
      chk("abort_busy", 32'(br.busy), 32'd0);
      chk("abort_done", 32'(br.done), 32'd0);
      chk("abort_idx", 32'(br.word_idx), 32'd0);
      step();
      chk("abort_no_done", 32'(br.done), 32'd0);
      start_pulse();
      stream5("fresh", 1'b0);
      // async reset mid-stream
      start_pulse();
      step();
      chk("pre_rst_valid", 32'(br.word_valid), 32'd1);
      #2 RST = 1'b0;
      #1;
      chk("arst_valid", 32'(br.word_valid), 32'd0);
      chk("arst_busy", 32'(br.busy), 32'd0);
      chk("arst_word", br.word_out, 32'd0);
      chk("arst_idx", 32'(br.word_idx), 32'd0);
      step();
      chk("arst_done", 32'(br.done), 32'd0);
      RST = 1'b1;
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
